// File: rtl/pbl_pkg.sv
// Shared types and default timing constants for the button conditioning slice.
package pbl_pkg;

   typedef enum logic [1:0] {
      SOLTO       = 2'd0,
      CONF_PRESS  = 2'd1,
      PRESSIONADO = 2'd2,
      CONF_SOLTA  = 2'd3
   } estado_t;

   localparam int unsigned DEB_TICKS_DEF  = 4;
   localparam int unsigned HOLD_TICKS_DEF = 64;
   localparam int unsigned REP_TICKS_DEF  = 16;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/modulo_debounce_canal.sv
// One button channel: 2-flop synchronizer, debounce FSM, stable-sample counter.
// Auto-repeat hold counter is built only with PBL_BOTOES_AUTO_REPEAT_EN defined.
module modulo_debounce_canal
   import pbl_pkg::*;
#(
   parameter int unsigned DEB_TICKS  = DEB_TICKS_DEF,
   parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
   parameter int unsigned REP_TICKS  = REP_TICKS_DEF
) (
   input  logic clk,
   input  logic clr,
   input  logic tick,
   input  logic btn_n,
   output logic btn_level,
   output logic btn_pulse
);

   if (DEB_TICKS < 2 || DEB_TICKS > 255 || HOLD_TICKS == 0 || REP_TICKS == 0) begin : g_param_check
      $error("modulo_debounce_canal: illegal timing parameters");
   end

   localparam logic [7:0] DEB_LIM = 8'(DEB_TICKS);

   logic    sync1_q, sync2_q;
   estado_t estado_q, estado_d;
   logic [7:0] cnt_q, cnt_d, cnt_inc;
   logic    level_q, level_d;
   logic    pulse_q, pulse_d;
   logic    s;

`ifdef PBL_BOTOES_AUTO_REPEAT_EN
   localparam logic [15:0] HOLD_LIM = 16'(HOLD_TICKS);
   localparam logic [15:0] REP_LIM  = 16'(HOLD_TICKS + REP_TICKS);
   logic [15:0] hold_q, hold_d, hold_inc;

   assign hold_inc = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) hold_q <= '0;
      else     hold_q <= hold_d;
   end
`endif

   assign s       = sync2_q;
   assign cnt_inc = sat_inc8(cnt_q);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         estado_q <= SOLTO;
         cnt_q    <= '0;
         level_q  <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         sync1_q  <= ~btn_n;
         sync2_q  <= sync1_q;
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         pulse_q  <= pulse_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      level_d  = level_q;
      pulse_d  = 1'b0;
`ifdef PBL_BOTOES_AUTO_REPEAT_EN
      hold_d   = hold_q;
`endif
      if (tick) begin
         unique case (estado_q)
            SOLTO: begin
               if (s) begin
                  estado_d = CONF_PRESS;
                  cnt_d    = 8'd1;
               end
            end
            CONF_PRESS: begin
               if (s) begin
                  if (cnt_inc == DEB_LIM) begin
                     estado_d = PRESSIONADO;
                     cnt_d    = '0;
                     level_d  = 1'b1;
                     pulse_d  = 1'b1;
`ifdef PBL_BOTOES_AUTO_REPEAT_EN
                     hold_d   = '0;
`endif
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  estado_d = SOLTO;
                  cnt_d    = '0;
               end
            end
            PRESSIONADO: begin
               if (!s) begin
                  estado_d = CONF_SOLTA;
                  cnt_d    = 8'd1;
               end
`ifdef PBL_BOTOES_AUTO_REPEAT_EN
               // after the first repeat, fold back to HOLD_LIM so the counter never runs away
               else begin
                  hold_d = hold_inc;
                  if (hold_inc == HOLD_LIM) begin
                     pulse_d = 1'b1;
                  end else if (hold_inc == REP_LIM) begin
                     pulse_d = 1'b1;
                     hold_d  = HOLD_LIM;
                  end
               end
`endif
            end
            CONF_SOLTA: begin
               if (!s) begin
                  if (cnt_inc == DEB_LIM) begin
                     estado_d = SOLTO;
                     cnt_d    = '0;
                     level_d  = 1'b0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  estado_d = PRESSIONADO;
                  cnt_d    = '0;
`ifdef PBL_BOTOES_AUTO_REPEAT_EN
                  hold_d   = '0;
`endif
               end
            end
            default: estado_d = SOLTO;
         endcase
      end
   end

   assign btn_level = level_q;
   assign btn_pulse = pulse_q;

endmodule

// File: rtl/modulo_condicionador_botoes.sv
// Button conditioner: N_BTN independent debounced channels with press strobes.
// Optional auto-repeat enabled by defining PBL_BOTOES_AUTO_REPEAT_EN.
module modulo_condicionador_botoes
   import pbl_pkg::*;
#(
   parameter int unsigned N_BTN      = 2,
   parameter int unsigned DEB_TICKS  = DEB_TICKS_DEF,
   parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
   parameter int unsigned REP_TICKS  = REP_TICKS_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             tick,
   input  logic [N_BTN-1:0] btn_n,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_canal
      modulo_debounce_canal #(
         .DEB_TICKS  (DEB_TICKS),
         .HOLD_TICKS (HOLD_TICKS),
         .REP_TICKS  (REP_TICKS)
      ) u_canal (
         .clk       (clk),
         .clr       (clr),
         .tick      (tick),
         .btn_n     (btn_n[i]),
         .btn_level (btn_level[i]),
         .btn_pulse (btn_pulse[i])
      );
   end

endmodule

// File: tb/tb_modulo_condicionador_botoes.sv
// Self-checking bench: directed scenarios plus random button activity against a run-length model.
module tb_modulo_condicionador_botoes;

   localparam int DEB  = 4;
   localparam int HOLD = 8;
   localparam int REP  = 4;

   logic       clk = 1'b0;
   logic       clr;
   logic       tick;
   logic [1:0] btn_n;
   logic [1:0] btn_level;
   logic [1:0] btn_pulse;

   int n_checks = 0;
   int n_fails  = 0;

   logic [1:0] m_level;
   int         m_run [2];
   int         m_h   [2];
   int         pcount[2];

   modulo_condicionador_botoes #(
      .N_BTN      (2),
      .DEB_TICKS  (DEB),
      .HOLD_TICKS (HOLD),
      .REP_TICKS  (REP)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .tick      (tick),
      .btn_n     (btn_n),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_level = 2'b00;
      for (int c = 0; c < 2; c++) begin
         m_run[c] = 0;
         m_h[c]   = 0;
      end
   endtask

   // Level flips after DEB consecutive samples disagreeing with it; a press strobes once.
   task automatic model_tick(input logic [1:0] s, output logic [1:0] p);
      p = 2'b00;
      for (int c = 0; c < 2; c++) begin
         if (!m_level[c]) begin
            if (s[c]) begin
               m_run[c]++;
               if (m_run[c] == DEB) begin
                  m_level[c] = 1'b1;
                  m_run[c]   = 0;
                  m_h[c]     = 0;
                  p[c]       = 1'b1;
               end
            end else begin
               m_run[c] = 0;
            end
         end else begin
            if (!s[c]) begin
               m_run[c]++;
               if (m_run[c] == DEB) begin
                  m_level[c] = 1'b0;
                  m_run[c]   = 0;
               end
            end else if (m_run[c] != 0) begin
               m_run[c] = 0;
               m_h[c]   = 0;
            end else begin
               m_h[c]++;
`ifdef PBL_BOTOES_AUTO_REPEAT_EN
               if (m_h[c] >= HOLD && ((m_h[c] - HOLD) % REP) == 0) p[c] = 1'b1;
`endif
            end
         end
      end
   endtask

   // One tick period (4 clk): button set at start, tick on the 4th edge.
   task automatic step(input logic [1:0] b);
      logic [1:0] ep;
      btn_n = ~b;
      tick  = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("pulse_idle", 32'(btn_pulse), 32'(0));
         chk("level_idle", 32'(btn_level), 32'(m_level));
      end
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      model_tick(b, ep);
      chk("pulse_tick", 32'(btn_pulse), 32'(ep));
      chk("level_tick", 32'(btn_level), 32'(m_level));
      for (int c = 0; c < 2; c++) pcount[c] += int'(btn_pulse[c]);
   endtask

   task automatic steps(input logic [1:0] b, input int n);
      for (int k = 0; k < n; k++) step(b);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      #1;
      chk("clr_level", 32'(btn_level), 32'(0));
      chk("clr_pulse", 32'(btn_pulse), 32'(0));
      model_reset();
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic zero_counts();
      pcount[0] = 0;
      pcount[1] = 0;
   endtask

   initial begin
      logic [1:0] b;
      clr   = 1'b1;
      tick  = 1'b0;
      btn_n = 2'b11;
      model_reset();
      zero_counts();
      repeat (3) @(negedge clk);
      chk("reset_level", 32'(btn_level), 32'(0));
      chk("reset_pulse", 32'(btn_pulse), 32'(0));
      clr = 1'b0;

      // clean press held 10 ticks, then release
      zero_counts();
      steps(2'b01, 10);
      steps(2'b00, 6);
      chk("clean_pulses", 32'(pcount[0]), 32'(1));

      // bounce: 2 pressed, 1 released, 5 pressed
      zero_counts();
      steps(2'b01, 2);
      step(2'b00);
      steps(2'b01, 5);
      steps(2'b00, 6);
      chk("bounce_pulses", 32'(pcount[0]), 32'(1));

      // press glitch, then release glitch while pressed
      zero_counts();
      step(2'b01);
      steps(2'b00, 3);
      chk("glitch_no_pulse", 32'(pcount[0]), 32'(0));
      steps(2'b01, 6);
      step(2'b00);
      steps(2'b01, 3);
      steps(2'b00, 6);
      chk("rel_glitch_pulses", 32'(pcount[0]), 32'(1));

      // clr during CONF_PRESS with button kept pressed
      zero_counts();
      steps(2'b01, 2);
      do_clr();
      steps(2'b01, 6);
      steps(2'b00, 6);
      chk("clr_requal_pulses", 32'(pcount[0]), 32'(1));

      // simultaneous presses, then clr while the pulse is high
      steps(2'b11, 4);
      chk("both_pulse", 32'(btn_pulse), 32'(2'b11));
      do_clr();
      steps(2'b11, 3);
      steps(2'b00, 6);

      // long hold on channel 1
      zero_counts();
      steps(2'b10, 20);
      steps(2'b00, 6);
`ifdef PBL_BOTOES_AUTO_REPEAT_EN
      chk("hold_pulses", 32'(pcount[1]), 32'(4));
`else
      chk("hold_pulses", 32'(pcount[1]), 32'(1));
`endif

      // random activity with long-ish runs and rare resets
      b = 2'b00;
      for (int k = 0; k < 300; k++) begin
         for (int c = 0; c < 2; c++)
            if ($urandom_range(0, 3) == 0) b[c] = ~b[c];
         if ($urandom_range(0, 63) == 0) do_clr();
         step(b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
